// File: rtl/spi_regbank_pkg.sv
// Shared frame geometry, address map constants and FSM state type for the
// SPI register-bank slave.
package spi_regbank_pkg;

  function automatic int FRAME_W(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int COMMIT_ADDR(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int CMT_BIT     = 0;
  localparam int CLR_ERR_BIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RX   = 1'b1
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage pin synchroniser with registered one-cycle rise/fall pulses;
// pin-to-pulse latency is STAGES+1 clk cycles.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= {STAGES{RESET_VAL}};
      prev <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
      fall <= ~sync[STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/spi_regbank_slave.sv
// SPI mode-0 slave with shadow/active register bank, atomic commit, MISO
// read-back and frame-length error counting.
module spi_regbank_slave
  import spi_regbank_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 28,
  parameter int NUM_REGS    = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       spi_clock,
  input  logic                       spi_cs_n,
  input  logic                       spi_mosi,
  output logic                       spi_miso,
  output logic                       spi_miso_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       commit_o,
  output logic                       frame_err_o
);

  localparam int FW    = FRAME_W(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(FW + 2);

  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FW);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FW + 1);
  localparam logic [CNT_W-1:0]  CNT_HDR  = CNT_W'(ADDR_W);
  localparam logic [ADDR_W-1:0] CMT_A    = ADDR_W'(COMMIT_ADDR(ADDR_W));
  localparam logic [ADDR_W-1:0] NREG_A   = ADDR_W'(NUM_REGS);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi_clock),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi_cs_n),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // One extra stage keeps MOSI aligned with the registered edge pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_sync <= '0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      mosi_s    <= mosi_sync[SYNC_STAGES-1];
    end
  end

  state_t state, state_nx;
  logic   start, shift, eval;

  logic [CNT_W-1:0]  bit_cnt;
  logic [FW-1:0]     rx_sr;
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic [DATA_W-1:0] active [NUM_REGS];
  logic [7:0]        err_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic              miso_r;
  logic              oe_r;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // A cs_n fall always wins over a coincident SCLK rise: IDLE ignores SCLK.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    shift    = 1'b0;
    eval     = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nx = RX;
          start    = 1'b1;
        end
      end
      RX: begin
        if (cs_rise) begin
          state_nx = IDLE;
          eval     = 1'b1;
        end else if (sclk_rise) begin
          shift = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic              f_rw;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data;
  logic [ADDR_W:0]   hdr;
  logic [DATA_W-1:0] rd_val;

  assign f_rw   = rx_sr[FW-1];
  assign f_addr = rx_sr[DATA_W +: ADDR_W];
  assign f_data = rx_sr[DATA_W-1:0];
  // Header as it will stand once the current MOSI bit is shifted in.
  assign hdr    = {rx_sr[ADDR_W-1:0], mosi_s};

  always_comb begin
    rd_val = '0;
    if (hdr[ADDR_W-1:0] < NREG_A)       rd_val = active[hdr[ADDR_W-1:0]];
    else if (hdr[ADDR_W-1:0] == CMT_A)  rd_val = {err_cnt, {(DATA_W-8){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      rx_sr       <= '0;
      err_cnt     <= '0;
      tx_sr       <= '0;
      miso_r      <= 1'b0;
      oe_r        <= 1'b0;
      commit_o    <= 1'b0;
      frame_err_o <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      commit_o    <= 1'b0;
      frame_err_o <= 1'b0;

      if (start) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
      end

      if (shift) begin
        rx_sr <= {rx_sr[FW-2:0], mosi_s};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == CNT_HDR && hdr[ADDR_W] == RW_READ) begin
          tx_sr <= rd_val;
          oe_r  <= 1'b1;
        end
      end

      if (sclk_fall && oe_r) begin
        miso_r <= tx_sr[DATA_W-1];
        tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
      end

      if (eval) begin
        oe_r   <= 1'b0;
        miso_r <= 1'b0;
        if (bit_cnt != CNT_FULL) begin
          frame_err_o <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end else if (f_rw == RW_WRITE) begin
          if (f_addr < NREG_A) begin
            shadow[f_addr] <= f_data;
          end else if (f_addr == CMT_A) begin
            if (f_data[CMT_BIT]) begin
              for (int k = 0; k < NUM_REGS; k++) active[k] <= shadow[k];
              commit_o <= 1'b1;
            end
            if (f_data[CLR_ERR_BIT]) err_cnt <= 8'd0;
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    assign regs_o[k*DATA_W +: DATA_W] = active[k];
  end

  assign spi_miso    = miso_r & oe_r;
  assign spi_miso_oe = oe_r;

endmodule

// File: tb/tb_spi_regbank_slave.sv
// Drives two slaves (7 and 5 data registers) from one SPI master and checks
// them against an array-based model of the register map.
module tb_spi_regbank_slave;

  localparam int HALF = 60;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_clock = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;

  logic miso0, oe0, commit0, ferr0;
  logic miso1, oe1, commit1, ferr1;
  logic [7*28-1:0] regs0;
  logic [5*28-1:0] regs1;

  always #5 clk = ~clk;

  spi_regbank_slave u_dut0 (
    .clk (clk), .rst_n (rst_n), .spi_clock (spi_clock), .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi), .spi_miso (miso0), .spi_miso_oe (oe0),
    .regs_o (regs0), .commit_o (commit0), .frame_err_o (ferr0)
  );

  spi_regbank_slave #(.NUM_REGS(5)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .spi_clock (spi_clock), .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi), .spi_miso (miso1), .spi_miso_oe (oe1),
    .regs_o (regs1), .commit_o (commit1), .frame_err_o (ferr1)
  );

  int checks = 0;
  int errors = 0;

  int commit_seen0 = 0, commit_seen1 = 0, ferr_seen0 = 0, ferr_seen1 = 0;
  always @(posedge clk) begin
    if (commit0) commit_seen0++;
    if (commit1) commit_seen1++;
    if (ferr0)   ferr_seen0++;
    if (ferr1)   ferr_seen1++;
  end

  // Reference model of the register map, one slot per DUT.
  logic [27:0] sh_m [2][8];
  logic [27:0] ac_m [2][8];
  int err_m [2];
  int ncommit_m [2];
  int nerr_m [2];
  int nregs [2] = '{7, 5};

  logic [63:0] rx0, rx1;
  int oe_bad0, oe_bad1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic rw, input logic [2:0] a, input logic [27:0] d);
    return {32'h0, rw, a, d};
  endfunction

  function automatic logic [27:0] rd_model(input int d, input int a);
    if (a < nregs[d]) return ac_m[d][a];
    if (a == 7) return {err_m[d][7:0], 20'h0};
    return 28'h0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      err_m[d] = 0;
      for (int k = 0; k < 8; k++) begin
        sh_m[d][k] = '0;
        ac_m[d][k] = '0;
      end
    end
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < 7; k++)
      check($sformatf("%s_r0_%0d", tag, k), 32'(regs0[k*28 +: 28]), 32'(ac_m[0][k]));
    for (int k = 0; k < 5; k++)
      check($sformatf("%s_r1_%0d", tag, k), 32'(regs1[k*28 +: 28]), 32'(ac_m[1][k]));
    check({tag, "_ncmt0"}, commit_seen0, ncommit_m[0]);
    check({tag, "_ncmt1"}, commit_seen1, ncommit_m[1]);
    check({tag, "_nerr0"}, ferr_seen0, nerr_m[0]);
    check({tag, "_nerr1"}, ferr_seen1, nerr_m[1]);
    check({tag, "_idle_oe"}, 32'({oe0, oe1, miso0, miso1}), 32'h0);
  endtask

  // Mode-0 master: MOSI set while SCLK low, MISO sampled just before each rise.
  task automatic xfer(input logic [63:0] f, input int n);
    logic hdr_rd, exp_oe;
    rx0 = '0; rx1 = '0; oe_bad0 = 0; oe_bad1 = 0;
    hdr_rd = (n > 0) ? f[n-1] : 1'b0;
    spi_cs_n = 1'b0;
    for (int k = 1; k <= n; k++) begin
      spi_mosi = f[n-k];
      #HALF;
      rx0 = {rx0[62:0], miso0};
      rx1 = {rx1[62:0], miso1};
      exp_oe = hdr_rd && (k >= 5);
      if (oe0 !== exp_oe) oe_bad0++;
      if (oe1 !== exp_oe) oe_bad1++;
      spi_clock = 1'b1;
      #HALF;
      spi_clock = 1'b0;
    end
    #HALF;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #100;
  endtask

  task automatic do_frame(input string tag, input logic [63:0] f, input int n);
    logic [27:0] exp_rd [2];
    logic rd;
    int a;
    rd = (n == 32) && f[31];
    a  = int'(f[30:28]);
    for (int d = 0; d < 2; d++) exp_rd[d] = rd_model(d, a);
    xfer(f, n);
    if (rd) begin
      check({tag, "_rd0"}, 32'(rx0[27:0]), 32'(exp_rd[0]));
      check({tag, "_rd1"}, 32'(rx1[27:0]), 32'(exp_rd[1]));
    end
    check({tag, "_oe0"}, oe_bad0, 0);
    check({tag, "_oe1"}, oe_bad1, 0);
    for (int d = 0; d < 2; d++) begin
      if (n != 32) begin
        if (err_m[d] < 255) err_m[d]++;
        nerr_m[d]++;
      end else if (!f[31]) begin
        if (a < nregs[d]) sh_m[d][a] = f[27:0];
        else if (a == 7) begin
          if (f[0]) begin
            for (int k = 0; k < 8; k++) ac_m[d][k] = sh_m[d][k];
            ncommit_m[d]++;
          end
          if (f[1]) err_m[d] = 0;
        end
      end
    end
    check_state(tag);
  endtask

  logic [63:0] fr;
  int nb;

  initial begin
    #2;
    model_reset();
    #100;
    rst_n = 1'b1;
    #100;
    check_state("reset");
    check("reset_pulses", 32'({commit0, ferr0, commit1, ferr1}), 32'h0);

    do_frame("wr1", mk(1'b0, 3'd1, 28'h1234567), 32);
    check("wr1_not_active", 32'(regs0[28 +: 28]), 32'h0);
    do_frame("cmt1", mk(1'b0, 3'd7, 28'h1), 32);
    check("cmt1_reg1", 32'(regs0[28 +: 28]), 32'h1234567);
    check("cmt1_once", commit_seen0, 1);

    do_frame("wr2", mk(1'b0, 3'd2, 28'hABCDEF0), 32);
    do_frame("rd2_pre", mk(1'b1, 3'd2, 28'h0), 32);
    check("rd2_pre_val", 32'(rx0[27:0]), 32'h0);
    do_frame("cmt2", mk(1'b0, 3'd7, 28'h1), 32);
    do_frame("rd2_post", mk(1'b1, 3'd2, 28'h0), 32);
    check("rd2_post_val", 32'(rx0[27:0]), 32'hABCDEF0);

    do_frame("short", mk(1'b0, 3'd0, 28'h5555555), 31);
    do_frame("long", mk(1'b0, 3'd0, 28'h2AAAAAA) << 1, 33);
    do_frame("rd_err2", mk(1'b1, 3'd7, 28'h0), 32);
    check("err_cnt_2", 32'(rx0[27:0]), 32'h0200000);
    do_frame("clr_err", mk(1'b0, 3'd7, 28'h2), 32);
    do_frame("rd_err0", mk(1'b1, 3'd7, 28'h0), 32);
    check("err_cnt_0", 32'(rx0[27:0]), 32'h0);

    do_frame("unmap_wr", mk(1'b0, 3'd6, 28'hCAFE123), 32);
    do_frame("unmap_cmt", mk(1'b0, 3'd7, 28'h1), 32);
    do_frame("unmap_rd", mk(1'b1, 3'd6, 28'h0), 32);
    check("unmap_rd1", 32'(rx1[27:0]), 32'h0);
    check("unmap_rd0", 32'(rx0[27:0]), 32'hCAFE123);

    for (int i = 0; i < 260; i++) do_frame("bad", 64'h0, int'($urandom_range(0, 5)));
    do_frame("rd_sat", mk(1'b1, 3'd7, 28'h0), 32);
    check("err_cnt_sat", 32'(rx0[27:20]), 32'd255);
    do_frame("clr_sat", mk(1'b0, 3'd7, 28'h2), 32);

    for (int i = 0; i < 30; i++) begin
      fr = mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 28'($urandom));
      nb = 32;
      if ($urandom_range(0, 7) == 0) begin
        fr[31] = 1'b0;
        if ($urandom_range(0, 1) == 1) nb = 31;
        else begin
          nb = 33;
          fr = fr << 1;
        end
      end
      do_frame("rand", fr, nb);
    end

    // Reset in the data phase of a read frame.
    fr = mk(1'b1, 3'd1, 28'h0);
    spi_cs_n = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      spi_mosi = fr[32-k];
      #HALF;
      spi_clock = 1'b1;
      #HALF;
      spi_clock = 1'b0;
    end
    #HALF;
    check("pre_rst_oe", 32'(oe0), 32'h1);
    rst_n = 1'b0;
    #50;
    model_reset();
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    check("rst_mid_pulses", 32'({commit0, ferr0, commit1, ferr1}), 32'h0);
    check_state("rst_mid");
    #50;
    rst_n = 1'b1;
    #100;
    for (int k = 0; k < 5; k++) begin
      spi_clock = 1'b1;
      #HALF;
      spi_clock = 1'b0;
      #HALF;
    end
    #100;
    check_state("idle_sclk");
    do_frame("post_wr", mk(1'b0, 3'd4, 28'h7654321), 32);
    do_frame("post_cmt", mk(1'b0, 3'd7, 28'h1), 32);
    check("post_reg4", 32'(regs0[4*28 +: 28]), 32'h7654321);
    check("post_reg1", 32'(regs0[28 +: 28]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_regbank_slave.md
# spi_regbank_slave

Parametrised SPI mode-0 slave owning the DDS control register bank, successor to the write-only 32-bit SPI register interface. Adds MISO read-back, double-buffered shadow/active registers with an explicit atomic commit, frame-length checking with an error counter, and a configurable synchroniser depth. It sits between the external SPI pins and the DDS core, whose frequency, phase, mode, gain and offset fields are sliced from `regs_o`.

## Interface
- `ADDR_W`, 3: address field width; address `2**ADDR_W-1` is reserved as COMMIT/STATUS.
- `DATA_W`, 28: data field width.
- `NUM_REGS`, 7: number of data registers; must be ≤ `2**ADDR_W-1`.
- `SYNC_STAGES`, 2: flip-flop depth of the pin synchronisers; minimum 2.
- `clk`  in  1: system clock; must be at least 8× the `spi_clock` frequency.
- `rst_n`  in  1: reset, synchronous, active-low.
- `spi_clock`  in  1: SCLK, asynchronous.
- `spi_cs_n`  in  1: chip select, active-low, asynchronous.
- `spi_mosi`  in  1: serial data in.
- `spi_miso`  out  1: serial data out; 0 when not driving.
- `spi_miso_oe`  out  1: MISO output enable for the pad.
- `regs_o`  out  NUM_REGS*DATA_W: active registers; register k is at `[k*DATA_W +: DATA_W]`.
- `commit_o`  out  1: one-cycle pulse when the active registers are loaded.
- `frame_err_o`  out  1: one-cycle pulse when a frame is discarded.

## Operation
- Frame, MSB first: `{rw, addr[ADDR_W-1:0], data[DATA_W-1:0]}`.
  - `FRAME_W = 1+ADDR_W+DATA_W`; this is 32 at the defaults.
  - `rw=1` is a read.
- All pins pass through `SYNC_STAGES` FFs. Synchroniser reset values: `spi_cs_n`=1, `spi_clock`=0.
- Edges are detected on the synchronised signals only.
- States:
  - IDLE → RX on the synchronised `cs_n` falling edge. Clear the bit counter and the rx shift register.
  - RX: on each SCLK rise, shift in MOSI and increment the counter. The counter saturates at `FRAME_W+1`.
  - RX → IDLE on the `cs_n` rising edge, which evaluates the frame. A `cs_n` rise in IDLE is ignored.
- Frame evaluation when `cs_n` rises:
  - **Count ≠ FRAME_W:** discard the frame, pulse `frame_err_o`, and saturating-increment the 8-bit `err_cnt`. No register changes.
  - **Write, addr < NUM_REGS:** `shadow[addr] <= data`. `regs_o` is unchanged.
  - **Write, addr = COMMIT:**
    - If `data[0]`, copy all shadow registers into the active registers and pulse `commit_o`.
    - If `data[1]`, clear `err_cnt`.
    - Both bits may be set in the same frame.
  - **Write, NUM_REGS ≤ addr < COMMIT:** ignored; this is not an error.
  - **Read:** no register state changes.
- Read data path:
  - On the SCLK rise that completes bit `1+ADDR_W` of a read frame, load `tx_sr` with the read value:
    - `active[addr]` for a data register;
    - `{err_cnt, zero-pad}` left-justified to `DATA_W` for COMMIT;
    - 0 for an unmapped address.
  - On each subsequent synchronised SCLK fall, `spi_miso <= tx_sr[DATA_W-1]` and `tx_sr` shifts left.
  - `spi_miso_oe` = 1 from that load until `cs_n` rises; otherwise 0. `spi_miso` is forced to 0 when `oe` = 0.
- Write frames never drive MISO.
- Reset: `regs_o`, shadows, `err_cnt`, `tx_sr`, the counter, `spi_miso`, `spi_miso_oe`, `commit_o` and `frame_err_o` all become 0; the state becomes IDLE.
  - Reset asserted mid-frame abandons the frame.
  - SCLK edges arriving in IDLE after reset are ignored.

## Timing
- Pin-to-event latency is `SYNC_STAGES+1` clk cycles: synchroniser stages plus one edge-detect register.
- The shadow update or commit takes effect on the clk edge after the detected `cs_n` rise.
  - The `regs_o` change and the `commit_o` pulse occur on the same cycle.
- MISO changes 1 clk after the detected SCLK fall. With `clk` ≥ 8× SCLK, the data is stable before the master samples on the next SCLK rise.
- The first read data bit is presented on the SCLK fall following the last address bit. This is standard mode-0 with a one-bit turnaround covered by the `rw`+addr header.
- A `cs_n` fall detected in the same cycle as an SCLK rise: the `cs_n` fall wins and that edge is not counted.
- Back-to-back frames are allowed with `cs_n` high for ≥ `SYNC_STAGES+2` clk cycles.

## Structure
- Package `spi_regbank_pkg` holds:
  - the `FRAME_W` function and `COMMIT_ADDR(ADDR_W)`;
  - the `RW_READ`/`RW_WRITE` constants;
  - the state enum IDLE/RX;
  - the COMMIT bit positions `CMT_BIT=0` and `CLR_ERR_BIT=1`.
- Sub-module `spi_sync_edge` (parameter STAGES, RESET_VAL) is a synchroniser plus rise/fall pulse outputs. It is instantiated for `spi_clock` and `spi_cs_n`. `spi_mosi` uses a plain synchroniser of equal depth so all three pins stay aligned.

## Test plan
- **Write then commit:** write addr 1 = 0x1234567, then COMMIT with data=1.
  - `regs_o[1]` stays 0 until the commit frame.
  - `commit_o` pulses once.
  - `regs_o[1]` = 0x1234567.
- **Write without commit, then read:** write addr 2 = 0xABCDEF0, then read addr 2.
  - MISO returns 0 (active value), and `spi_miso_oe` is high only during the data phase.
  - After a commit, the same read returns 0xABCDEF0 MSB first.
- **Short and long frames:** a 31-bit frame and a 33-bit frame to addr 0.
  - Two `frame_err_o` pulses; `regs_o` unchanged.
  - A read of COMMIT returns `err_cnt` = 2.
  - COMMIT write with data=2 clears `err_cnt` to 0.
- **Error counter saturation:** 260 bad frames → read of COMMIT returns `err_cnt` = 255.
- **Unmapped address:** write to an unmapped address (none exists at the default parameters, so run with `NUM_REGS=5`, addr 6).
  - No register change and no error.
  - A read of that address returns 0.
- **Reset mid-frame:** assert `rst_n`=0 after 16 bits.
  - All outputs read 0 and the state is IDLE.
  - A complete following frame is accepted normally.
